// File: rtl/md5_crack_pkg.sv
// Shared types and helpers for the MD5 brute-force controller.
package md5_crack_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;

  // Add inc (0..10) to one ASCII decimal character; returns {carry, ascii_sum}.
  function automatic logic [8:0] bcd_ascii_add(input logic [7:0] value, input logic [3:0] inc);
    logic [4:0] s;
    logic [4:0] d;
    s = {1'b0, value[3:0]} + {1'b0, inc};
    d = s - 5'd10;
    if (s >= 5'd10) return {1'b1, ASCII_ZERO[7:4], d[3:0]};
    else            return {1'b0, ASCII_ZERO[7:4], s[3:0]};
  endfunction

endpackage

// File: rtl/ascii_bcd_counter.sv
// One lane's candidate counter: ASCII decimal string advanced by STEP per increment.
module ascii_bcd_counter
  import md5_crack_pkg::*;
#(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned STEP   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  inc,
  input  logic [8*DIGITS-1:0]   load_value,
  output logic [8*DIGITS-1:0]   value,
  output logic                  wrapped,
  output logic                  carry_out
);

  localparam logic [3:0] STEP4 = 4'(STEP);

  logic [8*DIGITS-1:0] next_value;
  logic [8:0]          r;
  logic [3:0]          add;

  // Ripple the step through the digits, least significant character first.
  always_comb begin
    next_value = value;
    r          = '0;
    add        = STEP4;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      r                    = bcd_ascii_add(value[8*i +: 8], add);
      next_value[8*i +: 8] = r[7:0];
      add                  = {3'b000, r[8]};
    end
    carry_out = add[0];
  end

  // Counter register; the last issued value is held once the lane wraps.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      value   <= '0;
      wrapped <= 1'b0;
    end else if (load) begin
      value   <= load_value;
      wrapped <= 1'b0;
    end else if (inc && !wrapped) begin
      if (carry_out) wrapped <= 1'b1;
      else           value   <= next_value;
    end
  end

endmodule

// File: rtl/md5_crack_engine.sv
// Brute-force candidate generator, digest matcher and BCD millisecond timer.
module md5_crack_engine
  import md5_crack_pkg::*;
#(
  parameter int unsigned N_CORES     = 3,
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned CORE_LAT    = 64,
  parameter int unsigned CLK_HZ      = 100000000,
  parameter int unsigned TIME_DIGITS = 7
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [127:0]                  target_hash,
  output logic [N_CORES*8*DIGITS-1:0]   cand,
  output logic                          cand_valid,
  input  logic [N_CORES-1:0]            res_valid,
  input  logic [N_CORES*128-1:0]        res_hash,
  input  logic [N_CORES*8*DIGITS-1:0]   res_cand,
  output logic                          busy,
  output logic                          found,
  output logic                          exhausted,
  output logic [8*DIGITS-1:0]           pwd,
  output logic [4*TIME_DIGITS-1:0]      elapsed_bcd
);

  localparam int unsigned W    = 8*DIGITS;
  localparam int unsigned TICK = CLK_HZ/1000;
  localparam int unsigned PW   = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int unsigned DW   = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

  state_t                   state, state_nxt;
  logic                     accept_start, set_exh;
  logic [127:0]             target_q;
  logic [W-1:0]             lane_val     [N_CORES];
  logic                     lane_wrapped [N_CORES];
  logic                     lane_carry   [N_CORES];
  logic                     lane_inc, all_done, any_live, hit;
  logic [W-1:0]             hit_cand;
  logic [DW-1:0]            drain_cnt;
  logic [PW-1:0]            presc;
  logic [4*TIME_DIGITS-1:0] ms_next;
  logic                     ms_sat, ms_carry;

  assign busy       = (state == RUN) || (state == DRAIN);
  assign lane_inc   = (state == RUN);
  assign cand_valid = lane_inc && any_live;

  for (genvar g = 0; g < N_CORES; g++) begin : g_lane
    localparam logic [W-1:0] LANE_INIT = {DIGITS{ASCII_ZERO}} | W'(g);
    ascii_bcd_counter #(.DIGITS(DIGITS), .STEP(N_CORES)) u_cnt (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (abort),
      .load       (accept_start),
      .inc        (lane_inc),
      .load_value (LANE_INIT),
      .value      (lane_val[g]),
      .wrapped    (lane_wrapped[g]),
      .carry_out  (lane_carry[g])
    );
  end

  // Pack lanes onto the candidate bus and summarise wrap status.
  always_comb begin
    cand     = '0;
    all_done = 1'b1;
    any_live = 1'b0;
    for (int unsigned k = 0; k < N_CORES; k++) begin
      cand[k*W +: W] = lane_val[k];
      if (!lane_wrapped[k])                   any_live = 1'b1;
      if (!(lane_wrapped[k] || lane_carry[k])) all_done = 1'b0;
    end
  end

  // Digest compare; the lowest-numbered matching lane wins.
  always_comb begin
    hit      = 1'b0;
    hit_cand = '0;
    for (int unsigned k = 0; k < N_CORES; k++) begin
      if (!hit && res_valid[k] && (res_hash[k*128 +: 128] == target_q)) begin
        hit      = 1'b1;
        hit_cand = res_cand[k*W +: W];
      end
    end
  end

  // Next-state logic; abort overrides everything including start.
  always_comb begin
    state_nxt    = state;
    accept_start = 1'b0;
    set_exh      = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (start) begin state_nxt = RUN; accept_start = 1'b1; end
        RUN: begin
          if (hit)           state_nxt = DONE;
          else if (all_done) state_nxt = DRAIN;
        end
        DRAIN: begin
          if (hit) state_nxt = DONE;
          else if (drain_cnt == DW'(CORE_LAT-1)) begin
            state_nxt = DONE;
            set_exh   = 1'b1;
          end
        end
        DONE: if (start) begin state_nxt = RUN; accept_start = 1'b1; end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register, drain counter and result latches.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      drain_cnt <= '0;
      found     <= 1'b0;
      exhausted <= 1'b0;
      pwd       <= '0;
      target_q  <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
      if (abort) begin
        found     <= 1'b0;
        exhausted <= 1'b0;
      end else if (accept_start) begin
        found     <= 1'b0;
        exhausted <= 1'b0;
        target_q  <= target_hash;
      end else begin
        if (busy && hit) begin
          found <= 1'b1;
          pwd   <= hit_cand;
        end
        if (set_exh) exhausted <= 1'b1;
      end
    end
  end

  // Saturating BCD increment of the elapsed-ms count.
  always_comb begin
    ms_next  = elapsed_bcd;
    ms_sat   = 1'b1;
    ms_carry = 1'b1;
    for (int unsigned i = 0; i < TIME_DIGITS; i++) begin
      if (elapsed_bcd[4*i +: 4] != 4'd9) ms_sat = 1'b0;
      if (ms_carry) begin
        if (elapsed_bcd[4*i +: 4] == 4'd9) ms_next[4*i +: 4] = 4'd0;
        else begin
          ms_next[4*i +: 4] = elapsed_bcd[4*i +: 4] + 4'd1;
          ms_carry          = 1'b0;
        end
      end
    end
  end

  // Millisecond prescaler and timer; runs only while searching.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc       <= '0;
      elapsed_bcd <= '0;
    end else if (accept_start) begin
      presc       <= '0;
      elapsed_bcd <= '0;
    end else if (busy && !abort) begin
      if (presc == PW'(TICK-1)) begin
        presc <= '0;
        if (!ms_sat) elapsed_bcd <= ms_next;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_md5_crack_engine.sv
// Directed bench for md5_crack_engine with a delay-line model of the md5 cores.
module tb_md5_crack_engine;
  import md5_crack_pkg::*;

  localparam int L = 64;

  logic          clk = 1'b0;
  logic          reset_n, start, abort;
  logic [127:0]  target_hash;
  logic [47:0]   cand;
  logic          cand_valid;
  logic [2:0]    res_valid;
  logic [383:0]  res_hash;
  logic [47:0]   res_cand;
  logic          busy, found, exhausted;
  logic [15:0]   pwd;
  logic [7:0]    elapsed_bcd;

  logic          start2;
  logic [95:0]   cand2;
  logic          cand_valid2, busy2, found2, exhausted2;
  logic [2:0]    res_valid2;
  logic [383:0]  res_hash2;
  logic [95:0]   res_cand2;
  logic [31:0]   pwd2;
  logic [7:0]    elapsed2;

  logic          use_ovr;
  logic [2:0]    ovr_v;
  logic [383:0]  ovr_h;
  logic [47:0]   ovr_c;
  logic          pv [3][L];
  logic [15:0]   pc [3][L];

  int total = 0;
  int bad   = 0;
  int issues, exh_cyc, found_cyc;
  logic [127:0]  tx;

  always #5 clk = ~clk;

  md5_crack_engine #(.N_CORES(3), .DIGITS(2), .CORE_LAT(L), .CLK_HZ(10000), .TIME_DIGITS(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .target_hash(target_hash),
    .cand(cand), .cand_valid(cand_valid), .res_valid(res_valid), .res_hash(res_hash),
    .res_cand(res_cand), .busy(busy), .found(found), .exhausted(exhausted), .pwd(pwd),
    .elapsed_bcd(elapsed_bcd));

  md5_crack_engine #(.N_CORES(3), .DIGITS(4), .CORE_LAT(L), .CLK_HZ(10000), .TIME_DIGITS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .abort(1'b0), .target_hash(128'h0),
    .cand(cand2), .cand_valid(cand_valid2), .res_valid(res_valid2), .res_hash(res_hash2),
    .res_cand(res_cand2), .busy(busy2), .found(found2), .exhausted(exhausted2), .pwd(pwd2),
    .elapsed_bcd(elapsed2));

  function automatic logic [127:0] fh(input logic [15:0] c);
    return {8{c ^ 16'h5A3C}};
  endfunction

  // Core model: fixed-latency delay line per lane.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!reset_n) begin
        for (int j = 0; j < L; j++) begin
          pv[k][j] <= 1'b0;
          pc[k][j] <= '0;
        end
      end else begin
        pv[k][0] <= cand_valid;
        pc[k][0] <= cand[k*16 +: 16];
        for (int j = 1; j < L; j++) begin
          pv[k][j] <= pv[k][j-1];
          pc[k][j] <= pc[k][j-1];
        end
      end
    end
  end

  // Core outputs, optionally replaced by directed values.
  always_comb begin
    res_valid = '0;
    res_hash  = '0;
    res_cand  = '0;
    for (int k = 0; k < 3; k++) begin
      res_valid[k]            = use_ovr ? ovr_v[k]            : pv[k][L-1];
      res_cand[k*16 +: 16]    = use_ovr ? ovr_c[k*16 +: 16]   : pc[k][L-1];
      res_hash[k*128 +: 128]  = use_ovr ? ovr_h[k*128 +: 128] : fh(pc[k][L-1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; start2 = 1'b0;
    target_hash = '0; use_ovr = 1'b0; ovr_v = '0; ovr_h = '0; ovr_c = '0;
    res_valid2 = '0; res_hash2 = '0; res_cand2 = '0;
    repeat (4) tick();
    chk("rst_busy", busy, 0);
    chk("rst_cand_valid", cand_valid, 0);
    chk("rst_found", found, 0);
    chk("rst_exhausted", exhausted, 0);
    chk("rst_pwd", pwd, 0);
    chk("rst_elapsed", elapsed_bcd, 0);
    reset_n = 1'b1;
    tick();

    // Search for "07": lane 1 issues it in RUN cycle 2.
    target_hash = fh(16'h3037);
    pulse_start();
    chk("run0_cand_valid", cand_valid, 1);
    chk("run0_cand", cand, 48'h3032_3031_3030);
    tick(); tick();
    chk("run2_lane1", cand[31:16], 16'h3037);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_run_ignored", cand[15:0], 16'h3039);
    found_cyc = -1;
    for (int c = 3; c < 200 && found_cyc < 0; c++) begin
      if (found) found_cyc = c;
      else tick();
    end
    chk("found_cycle", found_cyc, 67);
    chk("found_pwd", pwd, 16'h3037);
    chk("found_busy", busy, 0);
    chk("found_cand_valid", cand_valid, 0);
    chk("found_exhausted", exhausted, 0);
    chk("found_elapsed", elapsed_bcd, 8'h06);
    repeat (80) tick();
    chk("done_timer_frozen", elapsed_bcd, 8'h06);

    // Unreachable target: wrap, drain, exhaust.
    target_hash = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    pulse_start();
    chk("restart_found_clr", found, 0);
    chk("restart_timer_clr", elapsed_bcd, 0);
    issues = 0; exh_cyc = -1;
    for (int c = 0; c < 300 && exh_cyc < 0; c++) begin
      if (cand_valid) issues++;
      if (exhausted) exh_cyc = c;
      else tick();
    end
    chk("issue_cycles", issues, 34);
    chk("exhaust_cycle", exh_cyc, 98);
    chk("exhaust_busy", busy, 0);
    chk("exhaust_found", found, 0);
    chk("exhaust_elapsed", elapsed_bcd, 8'h09);

    // Lanes 0 and 2 match together: lane 0 wins.
    tx = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    target_hash = tx;
    use_ovr = 1'b1;
    pulse_start();
    repeat (5) tick();
    ovr_v = 3'b101;
    ovr_h = {tx, 128'h0, tx};
    ovr_c = 48'h3232_3939_3131;
    tick();
    ovr_v = 3'b010;
    ovr_h = {128'h0, tx, 128'h0};
    ovr_c = 48'h0000_3434_0000;
    chk("prio_found", found, 1);
    chk("prio_pwd", pwd, 16'h3131);
    tick();
    chk("done_res_ignored", pwd, 16'h3131);
    ovr_v = '0;
    use_ovr = 1'b0;
    repeat (80) tick();

    // Abort at RUN cycle 10.
    target_hash = fh(16'h3037);
    pulse_start();
    repeat (10) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_cand_valid", cand_valid, 0);
    chk("abort_found", found, 0);
    chk("abort_elapsed_kept", elapsed_bcd, 8'h01);
    repeat (80) tick();
    chk("idle_res_ignored", found, 0);
    pulse_start();
    chk("restart_cand", cand, 48'h3032_3031_3030);
    chk("restart_cand_valid", cand_valid, 1);
    start = 1'b1; abort = 1'b1;
    tick();
    chk("abort_beats_start_run", busy, 0);
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_beats_start_idle", busy, 0);

    // Synchronous reset in the middle of a run.
    pulse_start();
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_cand_valid", cand_valid, 0);
    chk("midrst_pwd", pwd, 0);
    chk("midrst_elapsed", elapsed_bcd, 0);
    reset_n = 1'b1;
    tick();

    // Timer tick and saturation on the long-running instance.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    repeat (99) tick();
    chk("timer_99cyc", elapsed2, 8'h09);
    tick();
    chk("timer_100cyc", elapsed2, 8'h10);
    repeat (900) tick();
    chk("timer_saturate", elapsed2, 8'h99);
    repeat (200) tick();
    chk("timer_hold_99", elapsed2, 8'h99);
    chk("timer_busy", busy2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
